uart_rx_ld: RTL and testbench

- Serial receive front-end sitting directly upstream of the MCU's generic n-bit load/clear registers (input-port data register).
- Oversamples an asynchronous RX line, assembles 8N1 frames (LSB first) and presents each completed byte on data_out together with a one-cycle ld strobe.
- ld and data_out wire straight to the downstream register's ld and data_in pins.

---
 rtl/uart_rx_ld_pkg.sv | 20 ++
 rtl/uart_rx_ld_sync.sv | 28 ++
 rtl/uart_rx_ld.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_ld.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_ld_pkg.sv
// Shared types and helpers for the uart_rx_ld receive front-end.
// Optional parity support is enabled with UART_RX_PARITY_EN.
package uart_rx_ld_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } state_e;

   localparam int DEF_CLKS_PER_BIT = 868;

   function automatic int cnt_w(input int cpb);
      return (cpb > 2) ? $clog2(cpb) : 1;
   endfunction

endpackage

// File: rtl/uart_rx_ld_sync.sv
// Generic two-flop synchronizer for asynchronous inputs.
// Reset value is a parameter so idle-high lines come up inactive.
module sync_2ff #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_ld.sv
// Oversampling 8N1 UART receiver feeding a load/clear data register.
// Define UART_RX_PARITY_EN to add an even-parity bit and parity_err.
module uart_rx_ld
   import uart_rx_ld_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int DATA_W       = 8
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              rx,
   output logic [DATA_W-1:0] data_out,
   output logic              ld,
   output logic              frame_err,
`ifdef UART_RX_PARITY_EN
   output logic              parity_err,
`endif
   output logic              busy
);

   localparam int CW = cnt_w(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_W);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

   logic rx_s;

   sync_2ff #(
      .W       (1),
      .RST_VAL (1'b1)
   ) u_sync (
      .clk_i  (clk),
      .rst_ni (clr_n),
      .d_i    (rx),
      .q_o    (rx_s)
   );

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              ld_q, ld_d;
   logic              ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic              pbad_q, pbad_d;
   logic              perr_q, perr_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      bit_d   = bit_q;
      sh_d    = sh_q;
      data_d  = data_q;
      ld_d    = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_d  = pbad_q;
      perr_d  = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            if (cnt_q == HALF) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == FULL) begin
               cnt_d = '0;
               sh_d  = {rx_s, sh_q[DATA_W-1:1]};
               bit_d = bit_q + BW'(1);
               if (bit_q == LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
         PARITY: begin
`ifdef UART_RX_PARITY_EN
            if (cnt_q == FULL) begin
               cnt_d   = '0;
               pbad_d  = rx_s ^ (^sh_q);
               state_d = STOP;
            end
`else
            cnt_d   = '0;
            state_d = IDLE;
`endif
         end
         STOP: begin
            if (cnt_q == FULL) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (!rx_s) begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end else begin
`ifdef UART_RX_PARITY_EN
                  if (pbad_q) begin
                     perr_d = 1'b1;
                  end else begin
                     ld_d   = 1'b1;
                     data_d = sh_q;
                  end
`else
                  ld_d   = 1'b1;
                  data_d = sh_q;
`endif
               end
            end
         end
         BREAK: begin
            cnt_d = '0;
            if (rx_s) state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         data_q  <= '0;
         ld_q    <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         pbad_q  <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         data_q  <= data_d;
         ld_q    <= ld_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         pbad_q  <= pbad_d;
         perr_q  <= perr_d;
`endif
      end
   end

   assign data_out  = data_q;
   assign ld        = ld_q;
   assign frame_err = ferr_q;
   assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_ld.sv
// Directed and randomized frames checked against a byte-level model.
// Exercises parity frames too when UART_RX_PARITY_EN is defined.
module tb_uart_rx_ld;

   localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
   localparam logic PAR = 1'b1;
`else
   localparam logic PAR = 1'b0;
`endif
   localparam int FRAME = (PAR ? 11 : 10) * CPB;

   logic       clk   = 1'b0;
   logic       clr_n = 1'b0;
   logic       rx    = 1'b1;
   logic [7:0] data_out;
   logic       ld;
   logic       frame_err;
   logic       busy;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   uart_rx_ld #(
      .CLKS_PER_BIT (CPB),
      .DATA_W       (8)
   ) dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .rx         (rx),
      .data_out   (data_out),
      .ld         (ld),
      .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
      .parity_err (parity_err),
`endif
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int ld_cnt = 0;
   int ferr_cnt = 0;
   int perr_cnt = 0;
   int both_cnt = 0;
   int busy_at_ld = 0;
   logic [7:0] ld_data[$];
   int         ld_time[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (clr_n) begin
         if (ld) begin
            ld_cnt = ld_cnt + 1;
            ld_data.push_back(data_out);
            ld_time.push_back(cyc);
            if (busy) busy_at_ld = busy_at_ld + 1;
         end
         if (frame_err) ferr_cnt = ferr_cnt + 1;
         if (ld && frame_err) both_cnt = both_cnt + 1;
`ifdef UART_RX_PARITY_EN
         if (parity_err) perr_cnt = perr_cnt + 1;
`endif
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] get_data(input int i);
      if (i < ld_data.size()) return {24'h0, ld_data[i]};
      return 32'hDEADBEEF;
   endfunction

   function automatic int get_time(input int i);
      if (i < ld_time.size()) return ld_time[i];
      return -10000;
   endfunction

   task automatic bit_out(input logic b);
      rx = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d, input logic stop,
                       input logic pbit);
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) bit_out(d[i]);
      if (PAR) bit_out(pbit);
      bit_out(stop);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int n0, f0, p0, dt;
      logic seen, allhi;
      logic [7:0] last, d, v;
      logic good;
      int exp_f;
      logic [7:0] expq[$];

      rx = 1'b1;
      clr_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_data", {24'h0, data_out}, 32'h0);
      chk("rst_ld", {31'h0, ld}, 32'h0);
      chk("rst_ferr", {31'h0, frame_err}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      clr_n = 1'b1;
      idle(5);

      n0 = ld_cnt; f0 = ferr_cnt;
      send(8'hA5, 1'b1, ^8'hA5);
      idle(4);
      chk("a5_ld_cnt", ld_cnt - n0, 1);
      chk("a5_data", {24'h0, data_out}, 32'hA5);
      chk("a5_ferr", ferr_cnt - f0, 0);
      chk("a5_busy", {31'h0, busy}, 32'h0);

      n0 = ld_cnt;
      send(8'h00, 1'b1, 1'b0);
      send(8'hFF, 1'b1, 1'b0);
      idle(4);
      chk("b2b_ld_cnt", ld_cnt - n0, 2);
      chk("b2b_d0", get_data(n0), 32'h00);
      chk("b2b_d1", get_data(n0 + 1), 32'hFF);
      dt = get_time(n0 + 1) - get_time(n0);
      chk("b2b_spacing", {31'h0, (dt >= FRAME - 1 && dt <= FRAME + 1)}, 1);

      last = data_out;
      n0 = ld_cnt; f0 = ferr_cnt;
      rx = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
      end
      chk("glitch_busy_seen", {31'h0, seen}, 1);
      chk("glitch_ld", ld_cnt - n0, 0);
      chk("glitch_ferr", ferr_cnt - f0, 0);
      chk("glitch_data", {24'h0, data_out}, {24'h0, last});
      chk("glitch_idle", {31'h0, busy}, 0);

      n0 = ld_cnt; f0 = ferr_cnt;
      send(8'h3C, 1'b0, ^8'h3C);
      allhi = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (!busy) allhi = 1'b0;
      end
      chk("brk_ferr", ferr_cnt - f0, 1);
      chk("brk_ld", ld_cnt - n0, 0);
      chk("brk_data", {24'h0, data_out}, {24'h0, last});
      chk("brk_busy_held", {31'h0, allhi}, 1);
      idle(6);
      chk("brk_release", {31'h0, busy}, 0);

      v = 8'h81;
      n0 = ld_cnt; f0 = ferr_cnt;
      bit_out(1'b0);
      for (int i = 0; i < 4; i++) bit_out(v[i]);
      rx = v[4];
      repeat (8) @(negedge clk);
      clr_n = 1'b0;
      #1;
      chk("mid_rst_data", {24'h0, data_out}, 0);
      chk("mid_rst_ld", {31'h0, ld}, 0);
      chk("mid_rst_ferr", {31'h0, frame_err}, 0);
      chk("mid_rst_busy", {31'h0, busy}, 0);
      @(negedge clk);
      rx = 1'b1;
      repeat (4) @(negedge clk);
      clr_n = 1'b1;
      idle(4);
      chk("mid_rst_no_pulse", (ld_cnt - n0) + (ferr_cnt - f0), 0);
      send(8'h81, 1'b1, ^8'h81);
      idle(4);
      chk("post_rst_ld", ld_cnt - n0, 1);
      chk("post_rst_data", {24'h0, data_out}, 32'h81);

`ifdef UART_RX_PARITY_EN
      n0 = ld_cnt; p0 = perr_cnt;
      send(8'h07, 1'b1, 1'b0);
      idle(4);
      chk("par_bad_perr", perr_cnt - p0, 1);
      chk("par_bad_ld", ld_cnt - n0, 0);
      chk("par_bad_data", {24'h0, data_out}, 32'h81);
      send(8'h07, 1'b1, 1'b1);
      idle(4);
      chk("par_ok_ld", ld_cnt - n0, 1);
      chk("par_ok_data", {24'h0, data_out}, 32'h07);
      chk("par_ok_perr", perr_cnt - p0, 1);
`else
      p0 = perr_cnt;
`endif

      last = data_out;
      n0 = ld_cnt; f0 = ferr_cnt;
      exp_f = 0;
      expq.delete();
      for (int k = 0; k < 16; k++) begin
         d = 8'($urandom);
         good = ($urandom_range(0, 3) != 0);
         send(d, good, ^d);
         if (good) begin
            expq.push_back(d);
            last = d;
            idle($urandom_range(0, 20));
         end else begin
            exp_f++;
            repeat ($urandom_range(0, 30)) @(negedge clk);
            idle($urandom_range(4, 20));
         end
      end
      idle(4);
      chk("rand_ld_cnt", ld_cnt - n0, expq.size());
      chk("rand_ferr_cnt", ferr_cnt - f0, exp_f);
      foreach (expq[i]) chk("rand_data", get_data(n0 + i), {24'h0, expq[i]});
      chk("rand_last_data", {24'h0, data_out}, {24'h0, last});

      chk("ld_ferr_exclusive", both_cnt, 0);
      chk("busy_low_at_ld", busy_at_ld, 0);
      chk("no_stray_perr", perr_cnt - p0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
